// File: rtl/csd_scale_pkg.sv
// Shared definitions for the CSD constant scaler.
//   - mode_e       : constant select encodings (1, 1/sqrt2, cos(pi/8), sin(pi/8))
//   - csd_term_t   : one canonical-signed-digit term, weight = sign * 2^-exp
//   - csd_term()   : per-mode CSD table lookup, up to MAX_TERMS terms per mode
//   - ref_round()  : reference round-half-up of a value with F fractional bits
package csd_scale_pkg;

  // Largest CSD exponent in the table; the product keeps this many fraction bits.
  localparam int F         = 9;
  localparam int MAX_TERMS = 5;

  typedef enum logic [1:0] {
    MODE_ONE    = 2'd0,
    MODE_RSQRT2 = 2'd1,
    MODE_COS8   = 2'd2,
    MODE_SIN8   = 2'd3
  } mode_e;

  // en = term present, neg = subtract, exp = weight 2^-exp
  typedef struct packed {
    logic       en;
    logic       neg;
    logic [3:0] exp;
  } csd_term_t;

  function automatic csd_term_t mk_term(input logic neg, input int exp);
    csd_term_t t;
    t.en  = 1'b1;
    t.neg = neg;
    t.exp = 4'(exp);
    return t;
  endfunction

  // Terms are grouped so idx 0/1 and 2/3 form the two pair sums and idx 4
  // is the remaining term; unused slots are disabled.
  function automatic csd_term_t csd_term(input mode_e mode, input int idx);
    csd_term_t t;
    t = '0;
    case (mode)
      MODE_ONE: begin
        if (idx == 4) t = mk_term(1'b0, 0);
      end
      MODE_RSQRT2: begin  // 2^-1 + 2^-3 + 2^-4 + 2^-6 + 2^-8
        case (idx)
          0: t = mk_term(1'b0, 1);
          1: t = mk_term(1'b0, 3);
          2: t = mk_term(1'b0, 4);
          3: t = mk_term(1'b0, 6);
          4: t = mk_term(1'b0, 8);
          default: t = '0;
        endcase
      end
      MODE_COS8: begin    // 2^0 - 2^-4 - 2^-6 + 2^-9
        case (idx)
          0: t = mk_term(1'b0, 0);
          1: t = mk_term(1'b1, 4);
          2: t = mk_term(1'b1, 6);
          3: t = mk_term(1'b0, 9);
          default: t = '0;
        endcase
      end
      MODE_SIN8: begin    // 2^-2 + 2^-3 + 2^-7
        case (idx)
          0: t = mk_term(1'b0, 2);
          1: t = mk_term(1'b0, 3);
          4: t = mk_term(1'b0, 7);
          default: t = '0;
        endcase
      end
      default: t = '0;
    endcase
    return t;
  endfunction

  // Round half toward +infinity, dropping F fraction bits.
  function automatic longint ref_round(input longint p);
    return (p + (longint'(1) <<< (F - 1))) >>> F;
  endfunction

endpackage

// File: rtl/csd_scale_if.sv
// Sample/result bus of the CSD scaler.
//   master (producer/consumer side): drives ce, in_valid, in, mode, neg;
//                                    receives out_valid, out, sat
//   slave  (csd_scale):              the mirror image
interface csd_scale_if
  import csd_scale_pkg::*;
#(
  parameter int W = 16
);
  logic                ce;
  logic                in_valid;
  logic signed [W-1:0] in;
  mode_e               mode;
  logic                neg;
  logic                out_valid;
  logic signed [W-1:0] out;
  logic                sat;

  modport master (
    output ce, in_valid, in, mode, neg,
    input  out_valid, out, sat
  );

  modport slave (
    input  ce, in_valid, in, mode, neg,
    output out_valid, out, sat
  );
endinterface

// File: rtl/csd_scale_term_sum.sv
// csd_term_sum: combinational shift-and-add of one mode's CSD terms.
//   x      : signed input sample (W bits)
//   pair_a : term0 + term1, pair_b : term2 + term3, rest : term4
// Each term is x << (F - exp), so the outputs carry F fraction bits.
module csd_term_sum
  import csd_scale_pkg::*;
#(
  parameter int    W    = 16,
  parameter int    F    = csd_scale_pkg::F,
  parameter mode_e MODE = MODE_ONE,
  parameter int    PW   = W + F + 2
) (
  input  logic signed [W-1:0]  x,
  output logic signed [PW-1:0] pair_a,
  output logic signed [PW-1:0] pair_b,
  output logic signed [PW-1:0] rest
);

  function automatic logic signed [PW-1:0] term_val(input logic signed [W-1:0] v,
                                                   input csd_term_t t);
    logic signed [PW-1:0] e;
    e = PW'(v) <<< (F - int'(t.exp));
    if (!t.en) return '0;
    return t.neg ? -e : e;
  endfunction

  assign pair_a = term_val(x, csd_term(MODE, 0)) + term_val(x, csd_term(MODE, 1));
  assign pair_b = term_val(x, csd_term(MODE, 2)) + term_val(x, csd_term(MODE, 3));
  assign rest   = term_val(x, csd_term(MODE, 4));

endmodule

// File: rtl/csd_scale.sv
// csd_scale: 3-stage pipelined signed multiply by a selectable CSD constant,
// with optional negation, round-half-up and saturation to W = 2**N bits.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears every pipeline register
//   bus : csd_scale_if slave -- ce (stall), in_valid/in/mode/neg in,
//         out_valid/out/sat out
// Stages: S1 pair sums + remaining term, S2 full product,
//         S3 negate/round/saturate into the outputs.
module csd_scale
  import csd_scale_pkg::*;
#(
  parameter int N = 4,
  parameter int F = csd_scale_pkg::F
) (
  input  logic           clk,
  input  logic           rst,
  csd_scale_if.slave     bus
);

  localparam int W  = 2 ** N;
  localparam int PW = W + F + 2;

  localparam logic signed [PW-1:0] HALF    = PW'(1) <<< (F - 1);
  localparam logic signed [PW-1:0] MAX_OUT = (PW'(1) <<< (W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] MIN_OUT = -(PW'(1) <<< (W - 1));

  // Every mode is evaluated in parallel; mode only steers the S1 mux, so a
  // mode change takes effect on the very next sample.
  logic signed [PW-1:0] pair_a [4];
  logic signed [PW-1:0] pair_b [4];
  logic signed [PW-1:0] rest   [4];

  for (genvar g = 0; g < 4; g++) begin : g_mode
    csd_term_sum #(
      .W    (W),
      .F    (F),
      .MODE (mode_e'(g)),
      .PW   (PW)
    ) u_sum (
      .x      (bus.in),
      .pair_a (pair_a[g]),
      .pair_b (pair_b[g]),
      .rest   (rest[g])
    );
  end

  logic                 s1_valid, s1_neg;
  logic signed [PW-1:0] s1_pair_a, s1_pair_b, s1_rest;
  logic                 s2_valid, s2_neg;
  logic signed [PW-1:0] s2_sum;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rounded;
  logic signed [W-1:0]  res;
  logic                 res_sat;

  // Negation precedes rounding so that round-half-up stays biased toward
  // +infinity for negated products too.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, which is
    // what keeps this block free of inferred latches.
    res     = '0;
    res_sat = 1'b0;
    prod    = s2_neg ? -s2_sum : s2_sum;
    rounded = (prod + HALF) >>> F;
    if (rounded > MAX_OUT) begin
      res     = MAX_OUT[W-1:0];
      res_sat = 1'b1;
    end else if (rounded < MIN_OUT) begin
      res     = MIN_OUT[W-1:0];
      res_sat = 1'b1;
    end else begin
      res = rounded[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_neg        <= 1'b0;
      s1_pair_a     <= '0;
      s1_pair_b     <= '0;
      s1_rest       <= '0;
      s2_valid      <= 1'b0;
      s2_neg        <= 1'b0;
      s2_sum        <= '0;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.sat       <= 1'b0;
    end else if (bus.ce) begin
      // NOTE: non-blocking assignments let each stage read the previous
      // stage's old value, so the three stages advance in lockstep.
      s1_valid      <= bus.in_valid;
      s1_neg        <= bus.neg;
      s1_pair_a     <= pair_a[bus.mode];
      s1_pair_b     <= pair_b[bus.mode];
      s1_rest       <= rest[bus.mode];
      s2_valid      <= s1_valid;
      s2_neg        <= s1_neg;
      s2_sum        <= s1_pair_a + s1_pair_b + s1_rest;
      bus.out_valid <= s2_valid;
      bus.out       <= res;
      bus.sat       <= res_sat;
    end
  end

endmodule
